// File: rtl/dice_turn_engine.sv
// Two-button dice turn game: roll tumbles a die, hold banks the turn.
// Display outputs are registered and feed the 7-segment stage.
module dice_turn_engine #(
    parameter int TICK_MAX   = 4999999,
    parameter int BUST_TICKS = 20,
    parameter int TARGET     = 50
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ROLL_BTN,
    input  logic        HOLD_BTN,
    output logic [13:0] BIN,
    output logic [3:0]  DOT,
    output logic [2:0]  DIE,
    output logic        BUSY
);
    localparam int PW = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);
    localparam int BW = (BUST_TICKS < 2) ? 1 : $clog2(BUST_TICKS);
    localparam int TGT_C = (TARGET > 100) ? 100 : TARGET;
    localparam logic [6:0] TGT = 7'(TGT_C);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROLL,
        S_BUST,
        S_WIN
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [6:0]    bank_q, bank_d;
    logic [6:0]    turn_q, turn_d;
    logic [2:0]    die_q, die_d;
    logic          blink_q, blink_d;
    logic          roll_q, hold_q, armed_q;
    logic [13:0]   bin_q, bin_d;
    logic [3:0]    dot_q, dot_d;
    logic          busy_q, busy_d;
    logic [6:0]    field;

    logic       tick, roll_rise, roll_fall, hold_rise;
    logic [7:0] bank_sum, turn_sum;
    logic [6:0] bank_sat, turn_sat;

    // armed_q masks edges on the first cycle out of reset
    assign tick      = (presc_q == PW'(TICK_MAX));
    assign roll_rise = armed_q & ROLL_BTN & ~roll_q;
    assign roll_fall = armed_q & ~ROLL_BTN & roll_q;
    assign hold_rise = armed_q & HOLD_BTN & ~hold_q;

    assign bank_sum = {1'b0, bank_q} + {1'b0, turn_q};
    assign turn_sum = {1'b0, turn_q} + {5'd0, die_q};
    assign bank_sat = (bank_sum > 8'd99) ? 7'd99 : bank_sum[6:0];
    assign turn_sat = (turn_sum > 8'd99) ? 7'd99 : turn_sum[6:0];

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        bcnt_d  = bcnt_q;
        bank_d  = bank_q;
        turn_d  = turn_q;
        die_d   = die_q;
        blink_d = blink_q;
        unique case (state_q)
            S_IDLE: begin
                if (roll_rise) begin
                    state_d = S_ROLL;
                    presc_d = '0;
                end else if (hold_rise) begin
                    bank_d = bank_sat;
                    turn_d = '0;
                    if (bank_sat >= TGT) state_d = S_WIN;
                end
            end
            S_ROLL: begin
                if (roll_fall) begin
                    if (die_q == 3'd1) begin
                        turn_d  = '0;
                        state_d = S_BUST;
                        presc_d = '0;
                        bcnt_d  = '0;
                    end else begin
                        turn_d  = turn_sat;
                        state_d = S_IDLE;
                    end
                end else if (tick && ROLL_BTN) begin
                    die_d = (die_q == 3'd6) ? 3'd1 : die_q + 3'd1;
                end
            end
            S_BUST: begin
                if (tick) begin
                    if (bcnt_q == BW'(BUST_TICKS - 1)) begin
                        bcnt_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_WIN: begin
                if (tick) blink_d = ~blink_q;
            end
        endcase
    end

    always_comb begin
        field  = 7'd0;
        dot_d  = 4'b0000;
        busy_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                field = turn_q;
                dot_d = 4'b0100;
            end
            S_ROLL: begin
                field  = {4'd0, die_q};
                dot_d  = 4'b0101;
                busy_d = 1'b1;
            end
            S_BUST: begin
                dot_d  = 4'b1111;
                busy_d = 1'b1;
            end
            S_WIN: begin
                dot_d = blink_q ? 4'b1111 : 4'b0000;
            end
        endcase
        bin_d = 14'(bank_q) * 14'd100 + 14'(field);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            presc_q <= '0;
            bcnt_q  <= '0;
            bank_q  <= '0;
            turn_q  <= '0;
            die_q   <= 3'd1;
            blink_q <= 1'b0;
            roll_q  <= 1'b0;
            hold_q  <= 1'b0;
            armed_q <= 1'b0;
            bin_q   <= '0;
            dot_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            bcnt_q  <= bcnt_d;
            bank_q  <= bank_d;
            turn_q  <= turn_d;
            die_q   <= die_d;
            blink_q <= blink_d;
            roll_q  <= ROLL_BTN;
            hold_q  <= HOLD_BTN;
            armed_q <= 1'b1;
            bin_q   <= bin_d;
            dot_q   <= dot_d;
            busy_q  <= busy_d;
        end
    end

    assign BIN  = bin_q;
    assign DOT  = dot_q;
    assign DIE  = die_q;
    assign BUSY = busy_q;
endmodule

// File: doc/dice_turn_engine.md
DICE_TURN_ENGINE -- requirements
Module: dice_turn_engine

Interface
REQ-001 SHALL have parameter TICK_MAX, default 4999999, meaning the prescaler terminal count; one tumble tick occurs every TICK_MAX+1 cycles.
REQ-002 SHALL have parameter BUST_TICKS, default 20, meaning the number of ticks the BUST state is held.
REQ-003 SHALL have parameter TARGET, default 50, meaning the bank score at or above which the game is won.
REQ-004 SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port ROLL_BTN, input, 1 bit: debounced, CLK-synchronous roll button level.
REQ-007 SHALL have port HOLD_BTN, input, 1 bit: debounced, CLK-synchronous hold button level.
REQ-008 SHALL have port BIN, output, 14 bits: display value bank*100 + field, which feeds the binary-to-7-segment display stage.
REQ-009 SHALL have port DOT, output, 4 bits: decimal-point request per digit, bit0 = rightmost digit, 1 = lit.
REQ-010 SHALL have port DIE, output, 3 bits: current die face, 1..6.
REQ-011 SHALL have port BUSY, output, 1 bit: high in ROLLING and BUST.

Function
REQ-012 SHALL detect a rising or falling edge on each button by comparison with its value registered on the previous cycle.
REQ-013 SHALL run a prescaler that counts 0..TICK_MAX and wraps, with tick = (count==TICK_MAX).
- The prescaler is cleared when entering ROLLING or BUST, so the first tick falls TICK_MAX+1 cycles after entry.
REQ-014 SHALL implement FSM states IDLE, ROLLING, BUST and WIN.
REQ-015 SHALL, in IDLE, go to ROLLING on a ROLL_BTN rising edge.
- If both buttons show rising edges in the same cycle, ROLL wins and HOLD is ignored.
REQ-016 SHALL, in IDLE, handle a HOLD_BTN rising edge as follows:
- bank <= min(bank+turn, 99); turn <= 0.
- If the new bank >= TARGET, go to WIN; otherwise stay in IDLE.
REQ-017 SHALL, in ROLLING, advance DIE on each tick while ROLL_BTN is high: 1->2->...->6->1.
REQ-018 SHALL, in ROLLING, act on a ROLL_BTN falling edge using the DIE value held on that cycle:
- DIE==1: turn <= 0, go to BUST.
- Otherwise: turn <= min(turn+DIE, 99), go to IDLE.
- If a tick coincides with the falling edge, DIE does not advance on that cycle.
REQ-019 SHALL, in BUST, count ticks and return to IDLE on the cycle of the BUST_TICKS-th tick; button edges are ignored in BUST.
REQ-020 SHALL make WIN terminal until reset; all button edges are ignored in WIN.
REQ-021 SHALL hold bank and turn as 7-bit values, each saturating at 99.
REQ-022 SHALL register BIN, DOT and BUSY, so they reflect state and counters one cycle after those change.
REQ-023 SHALL drive the display fields per state as follows:
- IDLE: field = turn; DOT = 0100.
- ROLLING: field = DIE; DOT = 0101.
- BUST: field = 0; DOT = 1111.
- WIN: field = 0; DOT = 1111 when the tick-toggled blink bit is 1, else 0000.
REQ-024 SHALL keep BIN <= 9999 under all conditions.
REQ-025 SHALL hold DIE at its last face outside ROLLING.

Reset
REQ-026 SHALL, on the first CLK edge with RESET_N low, set: state=IDLE, bank=0, turn=0, DIE=1, prescaler=0, bust count=0, blink=0, BIN=0, DOT=0000, BUSY=0, and both edge registers=0.
REQ-027 SHALL give reset priority over all other activity in every state, including mid-ROLLING and mid-BUST; no partial score update survives it.
REQ-028 SHALL NOT register a rising edge on the first cycle after reset release if a button is already held high at that point.

Verification (TICK_MAX=3, BUST_TICKS=2, TARGET=10)
REQ-029 SHALL cover reset: hold RESET_N low 2 cycles with ROLL_BTN high, then release -> BIN=0, DOT=0000, DIE=1, BUSY=0, and the state stays IDLE.
REQ-030 SHALL cover a roll: raise ROLL_BTN, hold it 10 cycles, release -> 2 ticks occur, DIE=3, turn=3, state IDLE, and one cycle later BIN=3, DOT=0100.
REQ-031 SHALL cover bust: roll until DIE=1 at release -> turn=0, BIN=0, DOT=1111, BUSY=1 for 8 cycles, then IDLE with BIN=bank*100.
REQ-032 SHALL cover hold and win: turn=7 and bank=5, pulse HOLD_BTN -> bank=12, state WIN, BIN=1200, DOT toggling every 4 cycles, and further ROLL_BTN pulses ignored.
REQ-033 SHALL cover simultaneous edges and saturation: ROLL and HOLD rising together in IDLE -> ROLLING entered and bank unchanged; with turn=97, roll a 5 -> turn=99.
REQ-034 SHALL cover reset mid-roll: assert RESET_N low during ROLLING with turn=4 -> all counters reset, BIN=0, BUSY=0.
